// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine keypad/price entry path.
// Holds the converter FSM states, BCD digit constants and a counter width helper.
package vend_pkg;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } conv_state_e;

    // The counter must be able to hold BIN_W itself, reached on the final iteration.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bcd_to_binary_serial_adjust.sv
// Per-digit correction for reverse double dabble: subtract 3 when the nibble is
// at least 8, and flag nibbles that are not valid BCD.
module bcd_digit_adjust
    import vend_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o,
    output logic                   invalid_o
);

    // Correction and validity check; no carry leaves the nibble.
    always_comb begin
        digit_o   = digit_i;
        invalid_o = 1'b0;
        if (digit_i >= BCD_ADJ_THRESH) begin
            digit_o = digit_i - 4'd3;
        end else begin
            digit_o = digit_i;
        end
        if (digit_i > 4'd9) begin
            invalid_o = 1'b1;
        end else begin
            invalid_o = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_to_binary_serial.sv
// Iterative BCD-to-binary converter (reverse double dabble), one shift-and-correct
// step per clock, with a start/done handshake and an invalid-digit error flag.
module bcd_to_binary_serial
    import vend_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic [BIN_W-1:0]              bin_out_o
);

    localparam int DIG_W = BCD_DIGIT_W * DIGITS;
    localparam int SR_W  = DIG_W + BIN_W;
    localparam int CNT_W = cnt_width(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    conv_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIG_W-1:0] digits_q, digits_d;
    logic [BIN_W-1:0] bin_sr_q, bin_sr_d;
    logic [BIN_W-1:0] bin_out_q, bin_out_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SR_W-1:0]   shifted_s;
    logic [DIG_W-1:0]  adj_in_s;
    logic [DIG_W-1:0]  adj_out_s;
    logic [DIGITS-1:0] bad_s;
    logic              any_bad_s;

    assign shifted_s = {digits_q, bin_sr_q} >> 1;

    // The adjusters are shared: in IDLE they screen the incoming digits for
    // validity, in SHIFT they correct the freshly shifted digit nibbles.
    assign adj_in_s  = (state_q == S_SHIFT) ? shifted_s[SR_W-1:BIN_W] : bcd_in_i;
    assign any_bad_s = |bad_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i   (adj_in_s[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o   (adj_out_s[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .invalid_o (bad_s[g])
        );
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        digits_d  = digits_q;
        bin_sr_d  = bin_sr_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    digits_d  = bcd_in_i;
                    bin_sr_d  = '0;
                    cnt_d     = '0;
                    bin_out_d = '0;
                    if (any_bad_s) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_SHIFT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                digits_d = adj_out_s;
                bin_sr_d = shifted_s[BIN_W-1:0];
                cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    bin_out_d = shifted_s[BIN_W-1:0];
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            digits_q  <= '0;
            bin_sr_q  <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            bin_sr_q  <= bin_sr_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign bin_out_o = bin_out_q;

endmodule
